// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter_pkg
// Description : Shared definitions for the register writeback arbiter.
//               Default data/address widths and the requester-id encoding
//               used to track which requester was granted last.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_write_arbiter_pkg;

    localparam int c_WORD_WIDTH    = 32;
    localparam int c_ADDRESS_WIDTH = 5;

    // Requester identity; stored as last-grant state for round-robin.
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LONG = 1'b1
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register busy bits for long-latency destinations.
//               A long-latency issue marks its destination busy; the
//               matching writeback clears it. Drives decode stall and
//               issue back-pressure.
// Ports       : clk, rst          - clock, async active-high reset
//               issue_valid/addr  - long-latency issue request
//               issue_ready       - destination not already pending
//               clr_valid/addr    - accepted long-latency writeback
//               ra1, ra2          - decode source registers
//               stall             - a source has a pending write
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_addr,
    output logic                     issue_ready,
    input  logic                     clr_valid,
    input  logic [ADDRESS_WIDTH-1:0] clr_addr,
    input  logic [ADDRESS_WIDTH-1:0] ra1,
    input  logic [ADDRESS_WIDTH-1:0] ra2,
    output logic                     stall
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_next;

    // Clear is applied before set so a same-cycle set on the same register
    // wins. Register 0 is hard-wired to never be busy.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (issue_valid && issue_ready && (issue_addr != '0)) begin
            w_set_mask[issue_addr] = 1'b1;
        end
        if (clr_valid) begin
            w_clr_mask[clr_addr] = 1'b1;
        end
        w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign issue_ready = !rst && !r_busy[issue_addr];
    assign stall       = !rst && (((ra1 != '0) && r_busy[ra1]) ||
                                  ((ra2 != '0) && r_busy[ra2]));

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Arbitrates two writeback requesters (ALU path, long-latency
//               path) onto a single register-file write port with a one-
//               cycle registered drive, and tracks pending long-latency
//               destinations through reg_scoreboard.
// Ports       : clk, rst                 - clock, async active-high reset
//               req0_valid/addr/data     - ALU writeback request
//               req0_ready               - request 0 accepted this cycle
//               req1_valid/addr/data     - long-latency writeback request
//               req1_ready               - request 1 accepted this cycle
//               issue_valid/addr         - long-latency op issue
//               issue_ready              - issue accepted this cycle
//               RA1, RA2                 - decode source registers
//               stall                    - source has a pending write
//               WEN, WA3, WD3            - registered write port drive
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH    = c_WORD_WIDTH,
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [WORD_WIDTH-1:0]    req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [WORD_WIDTH-1:0]    req1_data,
    output logic                     req1_ready,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_addr,
    output logic                     issue_ready,
    input  logic [ADDRESS_WIDTH-1:0] RA1,
    input  logic [ADDRESS_WIDTH-1:0] RA2,
    output logic                     stall,
    output logic                     WEN,
    output logic [ADDRESS_WIDTH-1:0] WA3,
    output logic [WORD_WIDTH-1:0]    WD3
);

    req_id_e                  r_last_grant;
    logic                     r_wen;
    logic [ADDRESS_WIDTH-1:0] r_wa3;
    logic [WORD_WIDTH-1:0]    r_wd3;

    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_accept;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [WORD_WIDTH-1:0]    w_sel_data;

    // Round-robin: on a tie the requester that did not win last time wins.
    // Nothing is granted while reset is asserted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || (r_last_grant == REQ_LONG))) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_accept   = w_grant0 || w_grant1;
    assign w_sel_addr = w_grant1 ? req1_addr : req0_addr;
    assign w_sel_data = w_grant1 ? req1_data : req0_data;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Writes to register 0 are acknowledged but never enable the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_LONG;
            r_wen        <= 1'b0;
            r_wa3        <= '0;
            r_wd3        <= '0;
        end else begin
            r_wen <= w_accept && (w_sel_addr != '0);
            if (w_accept) begin
                r_wa3 <= w_sel_addr;
                r_wd3 <= w_sel_data;
            end
            if (w_grant0) begin
                r_last_grant <= REQ_ALU;
            end else if (w_grant1) begin
                r_last_grant <= REQ_LONG;
            end
        end
    end

    assign WEN = r_wen;
    assign WA3 = r_wa3;
    assign WD3 = r_wd3;

    reg_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .clr_valid   (w_grant1),
        .clr_addr    (req1_addr),
        .ra1         (RA1),
        .ra2         (RA2),
        .stall       (stall)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Directed, table-driven bench for reg_write_arbiter with
//               hand-written sequences for scoreboard and reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int WW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, issue_valid;
    logic [AW-1:0] req0_addr, req1_addr, issue_addr, RA1, RA2;
    logic [WW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready, issue_ready, stall, WEN;
    logic [AW-1:0] WA3;
    logic [WW-1:0] WD3;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .WORD_WIDTH    (WW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .RA1         (RA1),
        .RA2         (RA2),
        .stall       (stall),
        .WEN         (WEN),
        .WA3         (WA3),
        .WD3         (WD3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [WW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [WW-1:0] d1;
        logic          er0;
        logic          er1;
        logic          ewen;
        logic          chk_wr;
        logic [AW-1:0] ewa;
        logic [WW-1:0] ewd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        //           v0   a0     d0            v1   a1     d1            r0   r1   wen  chkw wa     wd
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44,      1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'h44};
        vecs[3]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1,  32'h11111111};
        vecs[4]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2,  32'h22222222};
        vecs[5]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1,  32'h11111111};
        vecs[6]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2,  32'h22222222};
        vecs[7]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h66,      1'b0, 1'b1, 1'b1, 1'b1, 5'd6,  32'h66};
        vecs[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[11] = '{1'b1, 5'd10, 32'hAAAA,     1'b1, 5'd11, 32'hBBBB,    1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'hBBBB};

        // Reset with requests pending: nothing may be granted.
        rst         = 1'b1;
        req0_valid  = 1'b1; req0_addr = 5'd3; req0_data = 32'h5;
        req1_valid  = 1'b1; req1_addr = 5'd4; req1_data = 32'h6;
        issue_valid = 1'b1; issue_addr = 5'd7;
        RA1 = 5'd7; RA2 = 5'd8;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst req0_ready", 32'(req0_ready), 32'd0);
        chk("rst req1_ready", 32'(req1_ready), 32'd0);
        chk("rst issue_ready", 32'(issue_ready), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst WEN", 32'(WEN), 32'd0);
        chk("rst WA3", 32'(WA3), 32'd0);
        chk("rst WD3", WD3, 32'd0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        RA1 = 5'd0; RA2 = 5'd0;
        #1;
        chk("post-rst issue_ready", 32'(issue_ready), 32'd1);

        // Arbitration table.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
            #1;
            chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].er0));
            chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].er1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d WEN", i), 32'(WEN), 32'(vecs[i].ewen));
            if (vecs[i].chk_wr) begin
                chk($sformatf("v%0d WA3", i), 32'(WA3), 32'(vecs[i].ewa));
                chk($sformatf("v%0d WD3", i), WD3, vecs[i].ewd);
            end
        end

        // Scoreboard: issue 7, stall on RA1=7, clear by req1 writeback.
        @(negedge clk);
        idle();
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        chk("sb issue7 ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        RA1 = 5'd7;
        #1;
        chk("sb stall ra1=7", 32'(stall), 32'd1);
        chk("sb issue7 busy ready", 32'(issue_ready), 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        #1;
        chk("sb req1 7 ready", 32'(req1_ready), 32'd1);
        chk("sb stall in accept cycle", 32'(stall), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("sb stall after clear", 32'(stall), 32'd0);
        chk("sb WEN 7", 32'(WEN), 32'd1);
        chk("sb WA3 7", 32'(WA3), 32'd7);
        @(negedge clk);
        #1;
        chk("sb stall two after", 32'(stall), 32'd0);
        chk("sb issue7 ready again", 32'(issue_ready), 32'd1);

        // Same-cycle set and clear on register 9: set wins.
        @(negedge clk);
        RA1 = 5'd0; RA2 = 5'd9;
        issue_valid = 1'b1; issue_addr = 5'd9;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
        #1;
        chk("sc issue9 ready", 32'(issue_ready), 32'd1);
        chk("sc req1 9 ready", 32'(req1_ready), 32'd1);
        chk("sc stall before", 32'(stall), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("sc stall set wins", 32'(stall), 32'd1);
        chk("sc WEN 9", 32'(WEN), 32'd1);
        chk("sc WA3 9", 32'(WA3), 32'd9);
        @(negedge clk);
        #1;
        chk("sc stall holds", 32'(stall), 32'd1);
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h98;
        #1;
        chk("sc req1 9 clear ready", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("sc stall cleared", 32'(stall), 32'd0);

        // Reset mid-operation.
        @(negedge clk);
        RA2 = 5'd0; RA1 = 5'd12;
        issue_valid = 1'b1; issue_addr = 5'd12;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h33;
        #1;
        chk("mr req1 3 ready", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        idle();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h44;
        #1;
        chk("mr stall busy12", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr async WEN", 32'(WEN), 32'd0);
        chk("mr async WA3", 32'(WA3), 32'd0);
        chk("mr async WD3", WD3, 32'd0);
        chk("mr rst stall", 32'(stall), 32'd0);
        chk("mr rst req0_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        issue_addr = 5'd12;
        #1;
        chk("mr busy cleared stall", 32'(stall), 32'd0);
        chk("mr busy cleared issue", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mr no write WEN", 32'(WEN), 32'd0);
        chk("mr no write WA3", 32'(WA3), 32'd0);
        @(posedge clk);
        #1;
        chk("mr no write WEN 2", 32'(WEN), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 32: register data width.
REQ-002 Parameter ADDRESS_WIDTH, default 5: register address width; 2**ADDRESS_WIDTH registers.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid/req0_addr/req0_data  input  1/ADDRESS_WIDTH/WORD_WIDTH  writeback request, pipeline ALU path.
REQ-006 req0_ready  output  1  request 0 accepted this cycle.
REQ-007 req1_valid/req1_addr/req1_data  input  1/ADDRESS_WIDTH/WORD_WIDTH  writeback request, long-latency path (load return / multicycle unit).
REQ-008 req1_ready  output  1  request 1 accepted this cycle.
REQ-009 issue_valid/issue_addr  input  1/ADDRESS_WIDTH  long-latency op issued with destination issue_addr.
REQ-010 issue_ready  output  1  issue accepted this cycle.
REQ-011 RA1, RA2  input  ADDRESS_WIDTH  source registers of the instruction in decode.
REQ-012 stall  output  1  a source register has a pending long-latency write.
REQ-013 WEN, WA3, WD3  output  1/ADDRESS_WIDTH/WORD_WIDTH  registered drive of the register file write port.

Function
REQ-014 At most one request SHALL be accepted per cycle; readyN SHALL be combinational from current valids and arbitration state.
REQ-015 Only one valid: that request SHALL be accepted.
REQ-016 Both valid: round-robin SHALL apply; the requester not granted last SHALL win; last_grant updates only on an accepted request.
REQ-017 An accepted request SHALL appear on WA3/WD3 with WEN=1 exactly one cycle after acceptance.
REQ-018 No request accepted: WEN SHALL be 0 next cycle; WA3/WD3 SHALL hold previous values.
REQ-019 Accepted request with addr=0 SHALL be acknowledged (ready=1) but SHALL produce WEN=0.
REQ-020 Scoreboard: one busy bit per register; busy[0] SHALL be constant 0.
REQ-021 issue_ready SHALL equal !busy[issue_addr]; on issue_valid&&issue_ready with issue_addr!=0, busy[issue_addr] SHALL set next cycle.
REQ-022 An accepted req1 SHALL clear busy[req1_addr] next cycle; req0 SHALL never clear busy bits.
REQ-023 Set and clear of the same register in one cycle: set SHALL win.
REQ-024 stall SHALL be combinational: (RA1!=0 && busy[RA1]) || (RA2!=0 && busy[RA2]).
REQ-025 req1 with busy[req1_addr]=0 SHALL still be written; no error reported.
REQ-026 Held valid with ready=0: requester keeps addr/data stable; arbiter SHALL not drop or duplicate it.

Reset
REQ-027 rst=1 SHALL immediately force WEN=0, WA3=0, WD3=0, all busy bits 0, last_grant=1 (req0 wins first tie).
REQ-028 While rst=1, req0_ready, req1_ready, issue_ready SHALL be 0 and stall SHALL be 0.
REQ-029 Reset mid-operation SHALL discard any accepted-but-not-yet-written request (no WEN after reset release for it).

Structure
REQ-030 Shared package SHALL hold WORD_WIDTH/ADDRESS_WIDTH defaults and a requester-id enum (REQ_ALU=0, REQ_LONG=1).
REQ-031 Scoreboard SHALL be a sub-module named reg_scoreboard (busy vector, set/clear, stall and issue_ready logic).
REQ-032 Arbitration and write-port register stage SHALL reside in reg_write_arbiter; reg_file SHALL be instantiated by the parent, not here.

Verification
REQ-033 After reset, req0 (addr=5, data=0xDEADBEEF) alone -> req0_ready=1; next cycle WEN=1, WA3=5, WD3=0xDEADBEEF.
REQ-034 Both valid 4 consecutive cycles (req0 addr=1, req1 addr=2) -> grants 0,1,0,1; WEN=1 every cycle after first.
REQ-035 issue addr=7, then RA1=7 -> stall=1; req1 addr=7 accepted -> stall=0 two cycles after acceptance cycle; issue addr=7 while busy -> issue_ready=0.
REQ-036 req0 addr=0 data=0x1234 -> req0_ready=1, WEN stays 0.
REQ-037 Same cycle: issue addr=9 and req1 addr=9 accepted (busy[9]=1) -> busy[9] remains 1, stall for RA2=9 stays 1.
REQ-038 Accept req1 addr=3, assert rst next cycle -> WEN=0, busy all 0, no write to 3 after release.
